mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port memory between the brainfuck CPU's instruction-fetch unit and its tape (data) unit. Serves one access per cycle, round-robin on conflict, and returns read data one cycle after grant. After reset, or on command, it sweeps the memory with zeros so the tape starts cleared. Sits between the CPU core and the memory block; it is the only master driving the memory port.

## Interface
Parameters:
- width_addr, 16, address width of memory and both requesters
- width_data, 16, data width
- clear_on_reset, 1, 1 = run the zero sweep after reset; 0 = go straight to service
- clear_depth, 2**width_addr, number of words zeroed by a sweep (addresses 0..clear_depth-1)

Ports:
- clk_in  in  1  clock, all state on rising edge
- reset_in  in  1  asynchronous, active-high reset
- clear_start_in  in  1  one-cycle pulse: start a zero sweep (ignored while busy_out=1)
- busy_out  out  1  sweep in progress; no grants while high
- fetch_req_in  in  1  fetch read request, held until granted
- fetch_addr_in  in  width_addr  fetch address, stable while fetch_req_in high
- fetch_gnt_out  out  1  fetch request accepted this cycle
- fetch_rvalid_out  out  1  fetch_rdata_out valid
- fetch_rdata_out  out  width_data  fetch read data
- data_req_in  in  1  tape request, held until granted
- data_we_in  in  1  1 = write, 0 = read
- data_addr_in  in  width_addr  tape address
- data_wdata_in  in  width_data  tape write data
- data_gnt_out  out  1  tape request accepted this cycle
- data_rvalid_out  out  1  data_rdata_out valid (reads only)
- data_rdata_out  out  width_data  tape read data
- mem_enable_out  out  1  memory access this cycle
- mem_is_write_out  out  1  memory write strobe
- mem_addr_out  out  width_addr  memory address
- mem_data_out  out  width_data  memory write data
- mem_data_in  in  width_data  memory read data, valid one cycle after a read issue

## Operation
- States: CLEAR, RUN. Reset enters CLEAR if clear_on_reset=1, else RUN.
- CLEAR: each cycle mem_enable_out=1, mem_is_write_out=1, mem_data_out=0, mem_addr_out=sweep counter; counter increments per cycle; the cycle writing clear_depth-1 transitions to RUN and resets counter to 0. busy_out=1 for exactly clear_depth cycles. Requests are held off (gnt=0).
- RUN: clear_start_in=1 -> CLEAR next cycle; no grant issued in the cycle clear_start_in is sampled.
- Grant (RUN, combinational from req): only one requester -> it wins; both -> the one not granted most recently. last-winner register resets to "data", so fetch wins the first conflict. Updated only on a conflict-free or conflict grant (every grant).
- Granted request drives mem_* in the same cycle: mem_enable_out=1, mem_is_write_out=data_we_in for tape, 0 for fetch.
- Read granted in cycle N -> corresponding rvalid_out=1 in cycle N+1 with rdata_out=mem_data_in. Writes produce no rvalid.
- rdata_out = 0 when rvalid_out=0. Fetch and tape rvalid never both high.
- A read granted in the cycle before clear_start_in/CLEAR entry still returns its rvalid.
- Idle RUN cycle: mem_enable_out=0, mem_is_write_out=0, addr/data outputs 0.

## Timing
- Reset (async, while reset_in=1): all gnt/rvalid/mem_enable_out/mem_is_write_out=0, rdata/addr/data outputs 0, sweep counter 0, pending-read flag cleared, busy_out=clear_on_reset. Reset mid-sweep restarts sweep from address 0; reset with a read in flight drops its rvalid.
- First grant possible in the first cycle busy_out=0.
- Throughput: one access per cycle; back-to-back grants to the same requester allowed when the other is idle.
- Starvation bound: a held request is granted within 2 RUN cycles.

## Test plan
- clear_on_reset=1, clear_depth=4: release reset -> mem writes 0 to addr 0,1,2,3 on 4 consecutive cycles, busy_out high 4 cycles, fetch_req held throughout granted on cycle 5.
- Fetch read addr 0x0010, memory returns 0x00AB -> fetch_gnt_out in cycle N, fetch_rvalid_out=1 and fetch_rdata_out=0x00AB in N+1 only.
- Both request continuously (fetch read 0x0001, tape read 0x0002) -> grants alternate fetch, data, fetch, data; rvalids alternate one cycle behind.
- Tape write 0x0005<-0x1234 then tape read 0x0005 -> write strobe with correct addr/data, no rvalid; read returns 0x1234.
- clear_start_in pulse in the cycle after a tape read grant -> rvalid for that read still delivered, then busy_out high clear_depth cycles, requests held off.
- Assert reset_in mid-sweep at counter 2 and with read in flight -> outputs zero immediately, no rvalid, sweep restarts at address 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and tape units.
// Round-robin on conflict; zero sweep after reset or on command.
module mem_arbiter #(
  parameter int width_addr     = 16,
  parameter int width_data     = 16,
  parameter bit clear_on_reset = 1'b1,
  parameter int clear_depth    = 2**width_addr
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  clear_start_in,
  output logic                  busy_out,
  input  logic                  fetch_req_in,
  input  logic [width_addr-1:0] fetch_addr_in,
  output logic                  fetch_gnt_out,
  output logic                  fetch_rvalid_out,
  output logic [width_data-1:0] fetch_rdata_out,
  input  logic                  data_req_in,
  input  logic                  data_we_in,
  input  logic [width_addr-1:0] data_addr_in,
  input  logic [width_data-1:0] data_wdata_in,
  output logic                  data_gnt_out,
  output logic                  data_rvalid_out,
  output logic [width_data-1:0] data_rdata_out,
  output logic                  mem_enable_out,
  output logic                  mem_is_write_out,
  output logic [width_addr-1:0] mem_addr_out,
  output logic [width_data-1:0] mem_data_out,
  input  logic [width_data-1:0] mem_data_in
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_INIT  =
    clear_on_reset ? ST_CLEAR : ST_RUN;
  localparam logic [width_addr-1:0] LAST_ADDR =
    width_addr'(clear_depth - 1);

  logic [0:0]            state_q, state_d;
  logic [width_addr-1:0] cnt_q, cnt_d;
  logic                  last_data_q, last_data_d;
  logic                  pend_f_q, pend_f_d;
  logic                  pend_d_q, pend_d_d;
  logic                  run;
  logic                  fetch_win;
  logic                  data_win;

  // Grant: the requester that did not win last time takes a conflict.
  always_comb begin
    run       = (state_q == ST_RUN) && !clear_start_in;
    fetch_win = run && fetch_req_in &&
                (!data_req_in || last_data_q);
    data_win  = run && data_req_in &&
                (!fetch_req_in || !last_data_q);
  end

  // Next state: sweep counter, mode, last winner, reads in flight.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else if (clear_start_in) begin
      state_d = ST_CLEAR;
    end
    if (fetch_win) begin
      last_data_d = 1'b0;
    end else if (data_win) begin
      last_data_d = 1'b1;
    end
    pend_f_d = fetch_win;
    pend_d_d = data_win && !data_we_in;
  end

  // State registers; a reset drops any read still in flight.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      last_data_q <= 1'b1;
      pend_f_q    <= 1'b0;
      pend_d_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      pend_f_q    <= pend_f_d;
      pend_d_q    <= pend_d_d;
    end
  end

  // Memory port mux: sweep, fetch, tape, or idle (all zero).
  always_comb begin
    mem_enable_out   = 1'b0;
    mem_is_write_out = 1'b0;
    mem_addr_out     = '0;
    mem_data_out     = '0;
    if (reset_in) begin
      mem_enable_out = 1'b0;
    end else if (state_q == ST_CLEAR) begin
      mem_enable_out   = 1'b1;
      mem_is_write_out = 1'b1;
      mem_addr_out     = cnt_q;
    end else if (fetch_win) begin
      mem_enable_out = 1'b1;
      mem_addr_out   = fetch_addr_in;
    end else if (data_win) begin
      mem_enable_out   = 1'b1;
      mem_is_write_out = data_we_in;
      mem_addr_out     = data_addr_in;
      if (data_we_in) begin
        mem_data_out = data_wdata_in;
      end
    end
  end

  // Grants are held low while reset is asserted.
  always_comb begin
    fetch_gnt_out    = fetch_win && !reset_in;
    data_gnt_out     = data_win && !reset_in;
    busy_out         = (state_q == ST_CLEAR);
    fetch_rvalid_out = pend_f_q;
    data_rvalid_out  = pend_d_q;
    fetch_rdata_out  = pend_f_q ? mem_data_in : '0;
    data_rdata_out   = pend_d_q ? mem_data_in : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus against
// a transaction-level reference of the arbiter.
module tb_mem_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_in;
  logic          clear_start_in;
  logic          busy_out;
  logic          fetch_req_in;
  logic [AW-1:0] fetch_addr_in;
  logic          fetch_gnt_out;
  logic          fetch_rvalid_out;
  logic [DW-1:0] fetch_rdata_out;
  logic          data_req_in;
  logic          data_we_in;
  logic [AW-1:0] data_addr_in;
  logic [DW-1:0] data_wdata_in;
  logic          data_gnt_out;
  logic          data_rvalid_out;
  logic [DW-1:0] data_rdata_out;
  logic          mem_enable_out;
  logic          mem_is_write_out;
  logic [AW-1:0] mem_addr_out;
  logic [DW-1:0] mem_data_out;
  logic [DW-1:0] mem_data_in;

  always #5 clk = ~clk;

  mem_arbiter #(
    .width_addr(AW),
    .width_data(DW),
    .clear_on_reset(1'b1),
    .clear_depth(DEPTH)
  ) dut (
    .clk_in(clk),
    .reset_in(reset_in),
    .clear_start_in(clear_start_in),
    .busy_out(busy_out),
    .fetch_req_in(fetch_req_in),
    .fetch_addr_in(fetch_addr_in),
    .fetch_gnt_out(fetch_gnt_out),
    .fetch_rvalid_out(fetch_rvalid_out),
    .fetch_rdata_out(fetch_rdata_out),
    .data_req_in(data_req_in),
    .data_we_in(data_we_in),
    .data_addr_in(data_addr_in),
    .data_wdata_in(data_wdata_in),
    .data_gnt_out(data_gnt_out),
    .data_rvalid_out(data_rvalid_out),
    .data_rdata_out(data_rdata_out),
    .mem_enable_out(mem_enable_out),
    .mem_is_write_out(mem_is_write_out),
    .mem_addr_out(mem_addr_out),
    .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in)
  );

  function automatic logic [15:0] init_val(
    input logic [7:0] a
  );
    return 16'hA500 ^ {a, a};
  endfunction

  // Memory block the arbiter drives: 1-cycle read latency.
  bit [DW-1:0] env_mem [256];
  bit          env_wr  [256];
  bit [DW-1:0] rd_q;
  assign mem_data_in = rd_q;

  always @(posedge clk) begin
    if (mem_enable_out) begin
      if (mem_is_write_out) begin
        env_mem[mem_addr_out[7:0]] <= mem_data_out;
        env_wr[mem_addr_out[7:0]]  <= 1'b1;
      end else begin
        rd_q <= env_wr[mem_addr_out[7:0]] ?
                env_mem[mem_addr_out[7:0]] :
                init_val(mem_addr_out[7:0]);
      end
    end
  end

  // Reference state.
  bit [DW-1:0] sh_mem [256];
  bit          sh_wr  [256];
  int          clr_left;
  int          last_winner;
  bit          pv_f, pv_d;
  logic [15:0] pv_dat;
  bit          g_f, g_d;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] sh_read(
    input logic [15:0] a
  );
    return sh_wr[a[7:0]] ? sh_mem[a[7:0]] : init_val(a[7:0]);
  endfunction

  task automatic sh_write(
    input logic [15:0] a,
    input logic [15:0] v
  );
    sh_mem[a[7:0]] = v;
    sh_wr[a[7:0]]  = 1'b1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare 1 ns later.
  task automatic step(
    input logic        fr,
    input logic [15:0] fa,
    input logic        dr,
    input logic        dwe,
    input logic [15:0] da,
    input logic [15:0] dwd,
    input logic        cs
  );
    bit          wf, wd, een, ewr, ebusy;
    logic [15:0] ea, ed;
    @(negedge clk);
    fetch_req_in   = fr;
    fetch_addr_in  = fa;
    data_req_in    = dr;
    data_we_in     = dwe;
    data_addr_in   = da;
    data_wdata_in  = dwd;
    clear_start_in = cs;
    #1;
    chk("f_rvalid", 32'(fetch_rvalid_out), 32'(pv_f));
    chk("f_rdata", 32'(fetch_rdata_out),
        pv_f ? 32'(pv_dat) : 32'd0);
    chk("d_rvalid", 32'(data_rvalid_out), 32'(pv_d));
    chk("d_rdata", 32'(data_rdata_out),
        pv_d ? 32'(pv_dat) : 32'd0);
    pv_f  = 0;
    pv_d  = 0;
    wf    = 0;
    wd    = 0;
    een   = 0;
    ewr   = 0;
    ebusy = 0;
    ea    = '0;
    ed    = '0;
    if (clr_left > 0) begin
      ebusy = 1;
      een   = 1;
      ewr   = 1;
      ea    = 16'(DEPTH - clr_left);
      sh_write(ea, 16'h0);
      clr_left--;
    end else if (cs) begin
      clr_left = DEPTH;
    end else begin
      if (fr && dr) begin
        if (last_winner == 1) wf = 1;
        else wd = 1;
      end else begin
        wf = fr;
        wd = dr;
      end
      if (wf) begin
        een         = 1;
        ea          = fa;
        pv_f        = 1;
        pv_dat      = sh_read(fa);
        last_winner = 0;
      end
      if (wd) begin
        een         = 1;
        ea          = da;
        ewr         = dwe;
        last_winner = 1;
        if (dwe) begin
          ed = dwd;
          sh_write(da, dwd);
        end else begin
          pv_d   = 1;
          pv_dat = sh_read(da);
        end
      end
    end
    chk("busy", 32'(busy_out), 32'(ebusy));
    chk("f_gnt", 32'(fetch_gnt_out), 32'(wf));
    chk("d_gnt", 32'(data_gnt_out), 32'(wd));
    chk("m_en", 32'(mem_enable_out), 32'(een));
    chk("m_wr", 32'(mem_is_write_out), 32'(ewr));
    chk("m_addr", 32'(mem_addr_out), 32'(ea));
    chk("m_data", 32'(mem_data_out), 32'(ed));
    g_f = wf;
    g_d = wd;
  endtask

  // Assert reset (optionally just after an edge) and check
  // that every output is forced quiet while it is held.
  task automatic do_reset(input bit after_edge);
    if (after_edge) begin
      @(posedge clk);
      #1;
    end
    fetch_req_in = 1'b1;
    data_req_in  = 1'b1;
    reset_in     = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_out), 32'd1);
    chk("rst_fgnt", 32'(fetch_gnt_out), 32'd0);
    chk("rst_dgnt", 32'(data_gnt_out), 32'd0);
    chk("rst_frv", 32'(fetch_rvalid_out), 32'd0);
    chk("rst_drv", 32'(data_rvalid_out), 32'd0);
    chk("rst_frd", 32'(fetch_rdata_out), 32'd0);
    chk("rst_drd", 32'(data_rdata_out), 32'd0);
    chk("rst_en", 32'(mem_enable_out), 32'd0);
    chk("rst_wr", 32'(mem_is_write_out), 32'd0);
    chk("rst_addr", 32'(mem_addr_out), 32'd0);
    chk("rst_data", 32'(mem_data_out), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_in     = 1'b0;
    fetch_req_in = 1'b0;
    data_req_in  = 1'b0;
    clr_left     = DEPTH;
    last_winner  = 1;
    pv_f         = 0;
    pv_d         = 0;
  endtask

  initial begin
    bit          fq, dq, weh, csr;
    logic [15:0] fah, dah, wdh;
    reset_in       = 1'b1;
    clear_start_in = 1'b0;
    fetch_req_in   = 1'b0;
    fetch_addr_in  = '0;
    data_req_in    = 1'b0;
    data_we_in     = 1'b0;
    data_addr_in   = '0;
    data_wdata_in  = '0;
    fq = 0;
    dq = 0;
    weh = 0;
    fah = '0;
    dah = '0;
    wdh = '0;
    do_reset(1'b0);

    // Fetch held through the sweep, granted on cycle 5.
    repeat (5) step(1, 16'h0010, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Both requesting continuously: grants alternate.
    repeat (6) step(1, 16'h0001, 1, 0, 16'h0002, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Tape write then read back; sweep-cleared word too.
    step(0, 0, 1, 1, 16'h0005, 16'h1234, 0);
    step(0, 0, 1, 0, 16'h0005, 0, 0);
    step(0, 0, 1, 0, 16'h0002, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Clear pulse right after a tape read grant.
    step(0, 0, 1, 0, 16'h0005, 0, 0);
    step(1, 16'h0005, 0, 0, 0, 0, 1);
    repeat (5) step(1, 16'h0005, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with held requests.
    repeat (1500) begin
      if (!fq && $urandom_range(0, 2) != 0) begin
        fq  = 1;
        fah = 16'($urandom_range(0, 15));
      end
      if (!dq && $urandom_range(0, 2) != 0) begin
        dq  = 1;
        dah = 16'($urandom_range(0, 15));
        weh = 1'($urandom_range(0, 1));
        wdh = 16'($urandom);
      end
      csr = ($urandom_range(0, 49) == 0);
      step(fq, fah, dq, weh, dah, wdh, csr);
      if (g_f) fq = 0;
      if (g_d) dq = 0;
    end
    repeat (DEPTH + 1) step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-sweep with the counter at 2.
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    do_reset(1'b0);
    repeat (DEPTH) step(0, 0, 0, 0, 0, 0, 0);

    // Reset with a fetch read in flight.
    step(1, 16'h0009, 0, 0, 0, 0, 0);
    do_reset(1'b1);
    repeat (DEPTH) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 16'h0009, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
